// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO with an exact fill level,
// registered full/empty/almost flags, sticky overflow/underflow and a
// synchronous flush.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// when undefined, reads have one cycle of registered latency.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_full,
    output logic                      wr_almost_full,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic                      rd_almost_empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [LW-1:0]         w_level_nxt;

    // Acceptance, error detection and next fill level; flush masks all requests.
    always_comb begin
        w_wr_acc    = 1'b0;
        w_rd_acc    = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else begin
            w_wr_acc  = wr_en && !r_full;
            w_rd_acc  = rd_en && !r_empty;
            w_ovf_set = wr_en && r_full;
            w_unf_set = rd_en && r_empty;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_level_nxt = r_level + LW'(1);
                2'b01:   w_level_nxt = r_level - LW'(1);
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // Pointers, level, flags (decoded ahead from next level) and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level        <= w_level_nxt;
            r_full         <= (w_level_nxt == LW'(DEPTH));
            r_almost_full  <= (w_level_nxt >= LW'(AF_THRESH));
            r_empty        <= (w_level_nxt == '0);
            r_almost_empty <= (w_level_nxt <= LW'(AE_THRESH));
            if (w_ovf_set) r_overflow  <= 1'b1;
            if (w_unf_set) r_underflow <= 1'b1;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is presented whenever the FIFO holds data.
    assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = !r_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // Registered read: data lands one cycle after the accepting edge and holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign wr_full         = r_full;
    assign wr_almost_full  = r_almost_full;
    assign rd_empty        = r_empty;
    assign rd_almost_empty = r_almost_empty;
    assign level           = r_level;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH=16, AF=14, AE=2) against a
// queue-based reference model.
module tb_sync_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;
    localparam int unsigned AE    = 2;
    localparam int unsigned LW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          wr_almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_empty;
    logic          rd_almost_empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic          exp_ovf   = 1'b0;
    logic          exp_unf   = 1'b0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_empty       (rd_empty),
        .rd_almost_empty(rd_almost_empty),
        .level          (level),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    // Drive one cycle of inputs, clock it, and advance the reference model.
    task automatic step(input logic r, input logic f, input logic we,
                        input logic [DW-1:0] wd, input logic re);
        bit full_b;
        bit empty_b;
        rst = r; flush = f; wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            exp_ovf = 1'b0; exp_unf = 1'b0; exp_valid = 1'b0; exp_data = '0;
        end else if (f) begin
            q.delete();
            exp_valid = 1'b0;
        end else begin
            full_b  = (q.size() == DEPTH);
            empty_b = (q.size() == 0);
            if (we && full_b)  exp_ovf = 1'b1;
            if (re && empty_b) exp_unf = 1'b1;
            exp_valid = 1'b0;
            if (re && !empty_b) begin
                exp_data  = q.pop_front();
                exp_valid = 1'b1;
            end
            if (we && !full_b) q.push_back(wd);
        end
`ifdef SYNC_FIFO_FWFT_EN
        exp_valid = (q.size() != 0);
        if (exp_valid) exp_data = q[0];
`endif
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b exp 1", rd_empty); end
        total++; if (rd_almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty: got %b exp 1", rd_almost_empty); end
        total++; if (wr_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b exp 0", wr_full); end
        total++; if (wr_almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull: got %b exp 0", wr_almost_full); end
        total++; if (level !== LW'(0)) begin bad++; $display("FAIL reset_level: got %0d exp 0", level); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", rd_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data: got %h exp 0", rd_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_unf: got %b exp 0", underflow); end
    endtask

    task automatic test_fill_drain();
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, DW'(i), 1'b0);
            total++; if (level !== LW'(i + 1)) begin bad++; $display("FAIL fill_level: got %0d exp %0d", level, i + 1); end
            total++; if (wr_almost_full !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_afull: level %0d got %b", i + 1, wr_almost_full); end
            total++; if (wr_full !== (i + 1 == 16)) begin bad++; $display("FAIL fill_full: level %0d got %b", i + 1, wr_full); end
            total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL fill_valid: got %b exp 0", rd_valid); end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b1);
            if (rd_valid === 1'b1) pulses++;
            total++; if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
                bad++; $display("FAIL drain_data: got v=%b d=%0d exp v=1 d=%0d", rd_valid, rd_data, i);
            end
        end
        total++; if (pulses != 16) begin bad++; $display("FAIL drain_pulses: got %0d exp 16", pulses); end
        total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b exp 1", rd_empty); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        total++; if (rd_valid !== 1'b0 || rd_data !== DW'(15)) begin
            bad++; $display("FAIL drain_hold: got v=%b d=%0d exp v=0 d=15", rd_valid, rd_data);
        end
        total++; if (underflow !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL drain_err: got ovf=%b unf=%b exp 0 0", overflow, underflow);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, DW'(100 + i), 1'b0);
        total++; if (wr_full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b exp 1", wr_full); end
        step(1'b0, 1'b0, 1'b1, DW'(99), 1'b1);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
        total++; if (level !== LW'(15)) begin bad++; $display("FAIL ovf_level: got %0d exp 15", level); end
        total++; if (rd_valid !== 1'b1 || rd_data !== DW'(100)) begin
            bad++; $display("FAIL ovf_head: got v=%b d=%0d exp v=1 d=100", rd_valid, rd_data);
        end
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b1);
            total++; if (rd_data !== DW'(100 + i) || rd_data === DW'(99)) begin
                bad++; $display("FAIL ovf_drain: got %0d exp %0d", rd_data, 100 + i);
            end
        end
        total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL ovf_empty: got %b exp 1", rd_empty); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b0);
            total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] hist[$];
        logic [DW-1:0] d;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            hist.push_back(d);
            step(1'b0, 1'b0, 1'b1, d, 1'b0);
        end
        total++; if (level !== LW'(3)) begin bad++; $display("FAIL wrap_start: got %0d exp 3", level); end
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            hist.push_back(d);
            step(1'b0, 1'b0, 1'b1, d, 1'b1);
            total++; if (level !== LW'(3)) begin bad++; $display("FAIL wrap_level: cyc %0d got %0d exp 3", i, level); end
            total++; if (rd_valid !== 1'b1 || rd_data !== hist[i]) begin
                bad++; $display("FAIL wrap_data: cyc %0d got v=%b d=%h exp %h", i, rd_valid, rd_data, hist[i]);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 1'b0);
        step(1'b1, 1'b0, 1'b1, DW'(7), 1'b1);
        total++; if (level !== LW'(0) || rd_empty !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL midreset: got lvl=%0d empty=%b ovf=%b exp 0 1 0", level, rd_empty, overflow);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, DW'(50 + i), 1'b0);
        total++; if (level !== LW'(5)) begin bad++; $display("FAIL flush_pre: got %0d exp 5", level); end
        step(1'b0, 1'b1, 1'b1, DW'(77), 1'b1);
        total++; if (level !== LW'(0)) begin bad++; $display("FAIL flush_level: got %0d exp 0", level); end
        total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL flush_empty: got %b exp 1", rd_empty); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b exp 0", rd_valid); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("FAIL flush_err: got ovf=%b unf=%b exp 0 0", overflow, underflow);
        end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL flush_unf: got %b exp 1", underflow); end
        total++; if (rd_valid !== 1'b0 || level !== LW'(0)) begin
            bad++; $display("FAIL flush_unf_state: got v=%b lvl=%0d exp 0 0", rd_valid, level);
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL flush_keep_unf: got %b exp 1", underflow); end
    endtask

    task automatic test_fwft();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'(32'hA5), 1'b0);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL fwft_valid: got %b exp 1", rd_valid); end
        total++; if (rd_data !== DW'(32'hA5)) begin bad++; $display("FAIL fwft_data: got %h exp a5", rd_data); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL fwft_empty: got %b exp 1", rd_empty); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop: got %b exp 0", rd_valid); end
    endtask

    task automatic test_random();
        int unsigned wp;
        int unsigned rp;
        logic r, f, we, re;
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            wp = ((i / 100) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 49) == 0);
            we = ($urandom_range(0, 99) < wp);
            re = ($urandom_range(0, 99) < rp);
            step(r, f, we, $urandom, re);
            total++; if (level !== LW'(q.size())) begin bad++; $display("FAIL rnd_level: cyc %0d got %0d exp %0d", i, level, q.size()); end
            total++; if (wr_full !== (q.size() == DEPTH) || wr_almost_full !== (q.size() >= AF)) begin
                bad++; $display("FAIL rnd_wflags: cyc %0d got f=%b af=%b size %0d", i, wr_full, wr_almost_full, q.size());
            end
            total++; if (rd_empty !== (q.size() == 0) || rd_almost_empty !== (q.size() <= AE)) begin
                bad++; $display("FAIL rnd_rflags: cyc %0d got e=%b ae=%b size %0d", i, rd_empty, rd_almost_empty, q.size());
            end
            total++; if (rd_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid: cyc %0d got %b exp %b", i, rd_valid, exp_valid); end
`ifdef SYNC_FIFO_FWFT_EN
            if (exp_valid) begin
                total++; if (rd_data !== exp_data) begin bad++; $display("FAIL rnd_data: cyc %0d got %h exp %h", i, rd_data, exp_data); end
            end
`else
            total++; if (rd_data !== exp_data) begin bad++; $display("FAIL rnd_data: cyc %0d got %h exp %h", i, rd_data, exp_data); end
`endif
            total++; if (overflow !== exp_ovf || underflow !== exp_unf) begin
                bad++; $display("FAIL rnd_err: cyc %0d got o=%b u=%b exp o=%b u=%b", i, overflow, underflow, exp_ovf, exp_unf);
            end
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        test_reset();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`else
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_flush();
`endif
        test_random();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO; successor to the `AsyncFifo` in-domain use case, for paths where writer and reader share one clock. It provides:
- full/empty flags and programmable almost-full/almost-empty thresholds;
- an exact fill level;
- sticky overflow/underflow error flags;
- a synchronous flush.

It sits between same-clock producers and consumers in the datapath and replaces the dual-clock FIFO wherever no CDC is required.

## Interface
- `DATA_WIDTH`, 32: bits per entry.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_THRESH`, `DEPTH-2`: `wr_almost_full` asserts when level ≥ `AF_THRESH`; legal range 1..`DEPTH`.
- `AE_THRESH`, 2: `rd_almost_empty` asserts when level ≤ `AE_THRESH`; legal range 0..`DEPTH-1`.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous clear of contents; has priority over `wr_en` and `rd_en`.
- `wr_en` input 1: write request.
- `wr_data` input `DATA_WIDTH`: write data.
- `wr_full` output 1: FIFO full.
- `wr_almost_full` output 1: level ≥ `AF_THRESH`.
- `rd_en` input 1: read request (pop).
- `rd_data` output `DATA_WIDTH`: read data.
- `rd_valid` output 1: `rd_data` holds valid data.
- `rd_empty` output 1: FIFO empty.
- `rd_almost_empty` output 1: level ≤ `AE_THRESH`.
- `level` output `$clog2(DEPTH)+1`: current number of stored entries.
- `overflow` output 1: sticky; a write was attempted while full.
- `underflow` output 1: sticky; a read was attempted while empty.

## Operation
- **Storage:** `DEPTH` × `DATA_WIDTH` memory addressed by write and read pointers, each `$clog2(DEPTH)` bits; both wrap modulo `DEPTH` with no special case.
- **Write acceptance:** a write is accepted iff `wr_en && !wr_full`. A rejected write does not modify memory or pointers, and sets `overflow`.
- **Read acceptance:** a read is accepted iff `rd_en && !rd_empty`. A rejected read leaves all state unchanged, and sets `underflow`.
- **Level:**
  - +1 on an accepted write only;
  - −1 on an accepted read only;
  - unchanged when both are accepted in the same cycle.
- **Flags:**
  - `wr_full` = (level == `DEPTH`);
  - `rd_empty` = (level == 0);
  - almost flags as defined in the Interface section.
  - All flags are decoded from the registered level, so they reflect state after the previous edge.
- **Full + simultaneous read/write:** the read is accepted and the write is rejected (`overflow` sets); level becomes `DEPTH-1`.
- **Empty + simultaneous read/write:** the write is accepted and the read is rejected (`underflow` sets); level becomes 1.
- **Flush:**
  - pointers and level go to 0;
  - `rd_valid` goes to 0;
  - any `wr_en`/`rd_en` in the same cycle is ignored and raises no error flag;
  - `overflow`/`underflow` are not cleared by flush.
- **Reset:** `rst` clears everything, including the sticky flags. Reset asserted mid-burst discards all contents. Memory contents need not be cleared.

## Timing
- **Reset values:**
  - `wr_full`=0, `wr_almost_full`=0, `rd_empty`=1, `rd_almost_empty`=1;
  - `level`=0, `rd_data`=0, `rd_valid`=0, `overflow`=0, `underflow`=0.
- **Standard mode:**
  - a read accepted at edge N drives the entry on `rd_data` with `rd_valid`=1 after edge N (latency 1);
  - `rd_valid` is a one-cycle pulse per accepted read;
  - `rd_data` holds its last value otherwise.
- **Write-to-read:** a write accepted at edge N makes `rd_empty`=0 after edge N; the earliest accepted read is at edge N+1.
- **Flag update:** `level` and all flags update one cycle after the accepting edge; there are no combinational paths from `wr_en`/`rd_en` to any flag.
- **Throughput:** sustained 1 write + 1 read per cycle, with no bubbles, at any level from 1 to `DEPTH-1`.

## Configuration
- Macro: `SYNC_FIFO_FWFT_EN`.
- **Defined (first-word-fall-through):**
  - `rd_data` presents the head entry whenever `rd_empty`=0;
  - `rd_valid` = !`rd_empty`;
  - `rd_en` acknowledges and pops the head, and the next entry appears after that edge;
  - write-to-`rd_valid` latency is 1 cycle;
  - all acceptance, level and error rules are unchanged.
- **Undefined:** standard registered-read mode, as described in Timing.

## Test plan
- **Reset defaults:** `DEPTH`=16. Hold `rst` for 2 cycles, then release. Required: `rd_empty`=1, `rd_almost_empty`=1, `level`=0, `rd_valid`=0, `overflow`=0, `underflow`=0.
- **Fill and drain:** write 0..15 on consecutive cycles, then read 16 times.
  - `wr_almost_full` rises when `level`=14.
  - `wr_full` rises when `level`=16.
  - `rd_data` returns 0..15 in order, with 16 `rd_valid` pulses.
  - After the last read, `rd_empty`=1.
- **Overflow:** with the FIFO full, assert `wr_en` with data 99 and `rd_en` in the same cycle. Required: `overflow`=1, `level`=15, 99 is never read, and `overflow` stays 1 until `rst`.
- **Wrap-around:** run 40 cycles of simultaneous write/read at `level`=3.
  - `level` stays 3 throughout.
  - Read data equals write data delayed by 3 entries across the pointer wrap.
- **Flush priority:** at `level`=5, assert `flush` together with `wr_en` and `rd_en`.
  - Next cycle: `level`=0, `rd_empty`=1, no `rd_valid`, no error flag set.
  - Then `rd_en` while empty → `underflow`=1.
- **FWFT build** (`SYNC_FIFO_FWFT_EN` defined): write 0xA5 into the empty FIFO at edge N.
  - After edge N: `rd_valid`=1 and `rd_data`=0xA5.
  - `rd_en` at edge N+1 → `rd_empty`=1 and `rd_valid`=0 after that edge.
